// File: rtl/vit_encoder_seq_ctrl.sv
// Multi-layer ViT encoder sequencer: LN1/ATT/RES1/LN2/batched MLP/RES2 per layer.
// Optional wait-state watchdog enabled by defining VIT_SEQ_TIMEOUT_EN.
module vit_encoder_seq_ctrl #(
  parameter int unsigned NUM_LAYERS    = 4,
  parameter int unsigned SEQ_LEN       = 8,
  parameter int unsigned TOK_PER_BATCH = 1,
  parameter int unsigned TIMEOUT_CYC   = 4096,
  localparam int unsigned LIDX_W  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int unsigned TBASE_W = $clog2(SEQ_LEN + 1),
  localparam int unsigned TCNT_W  = $clog2(TOK_PER_BATCH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic               ln1_start,
  output logic               attn_start,
  output logic               res1_start,
  output logic               ln2_start,
  output logic               mlp_start,
  output logic               res2_start,
  input  logic               ln1_done,
  input  logic               attn_done,
  input  logic               res1_done,
  input  logic               ln2_done,
  input  logic               mlp_done,
  input  logic               res2_done,
  output logic [LIDX_W-1:0]  layer_idx,
  output logic               buf_sel,
  output logic [TBASE_W-1:0] mlp_tok_base,
  output logic [TCNT_W-1:0]  mlp_tok_cnt
);

  if (NUM_LAYERS < 1 || SEQ_LEN < 1 || TOK_PER_BATCH < 1 ||
      TOK_PER_BATCH > SEQ_LEN || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("vit_encoder_seq_ctrl: illegal parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_LN1, S_W_LN1, S_ATT, S_W_ATT, S_RES1, S_W_RES1, S_LN2,
    S_W_LN2, S_MLP, S_W_MLP, S_RES2, S_W_RES2, S_DONE, S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LIDX_W-1:0]   w_layer_nxt;
  logic                w_buf_nxt;
  logic [TBASE_W-1:0]  w_base_nxt;
  logic [TBASE_W-1:0]  w_base_sum;
  logic [TCNT_W-1:0]   w_cnt_nxt;
  logic                w_err_nxt;

`ifdef VIT_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC);
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_is_wait;
  assign w_is_wait = r_state inside {S_W_LN1, S_W_ATT, S_W_RES1, S_W_LN2, S_W_MLP, S_W_RES2};
`endif

  // Size of the MLP batch starting at token 'base' (last batch may be short).
  function automatic logic [TCNT_W-1:0] batch_cnt(input logic [TBASE_W-1:0] base);
    logic [TBASE_W-1:0] rem;
    rem = TBASE_W'(SEQ_LEN) - base;
    if (rem > TBASE_W'(TOK_PER_BATCH)) return TCNT_W'(TOK_PER_BATCH);
    else return TCNT_W'(rem);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_layer_nxt = layer_idx;
    w_buf_nxt   = buf_sel;
    w_base_nxt  = mlp_tok_base;
    w_cnt_nxt   = mlp_tok_cnt;
    w_err_nxt   = err_timeout;
    w_base_sum  = mlp_tok_base + TBASE_W'(mlp_tok_cnt);
    if (abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          w_state_nxt = S_LN1;
          w_layer_nxt = '0;
          w_buf_nxt   = 1'b0;
          w_base_nxt  = '0;
          w_err_nxt   = 1'b0;
        end
        S_LN1:    w_state_nxt = S_W_LN1;
        S_W_LN1:  if (ln1_done) w_state_nxt = S_ATT;
        S_ATT:    w_state_nxt = S_W_ATT;
        S_W_ATT:  if (attn_done) w_state_nxt = S_RES1;
        S_RES1:   w_state_nxt = S_W_RES1;
        S_W_RES1: if (res1_done) begin
          w_state_nxt = S_LN2;
          w_base_nxt  = '0;
        end
        S_LN2:    w_state_nxt = S_W_LN2;
        S_W_LN2:  if (ln2_done) begin
          w_state_nxt = S_MLP;
          w_cnt_nxt   = batch_cnt(mlp_tok_base);
        end
        S_MLP:    w_state_nxt = S_W_MLP;
        S_W_MLP:  if (mlp_done) begin
          w_base_nxt = w_base_sum;
          if (w_base_sum == TBASE_W'(SEQ_LEN)) begin
            w_state_nxt = S_RES2;
          end else begin
            w_state_nxt = S_MLP;
            w_cnt_nxt   = batch_cnt(w_base_sum);
          end
        end
        S_RES2:   w_state_nxt = S_W_RES2;
        S_W_RES2: if (res2_done) begin
          if (layer_idx == LIDX_W'(NUM_LAYERS - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LN1;
            w_layer_nxt = layer_idx + LIDX_W'(1);
            w_buf_nxt   = ~buf_sel;
          end
        end
        S_DONE:   w_state_nxt = S_IDLE;
        S_ERR:    w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
`ifdef VIT_SEQ_TIMEOUT_EN
    // Watchdog only fires when the wait state would otherwise hold.
    w_wait_nxt = '0;
    if (w_is_wait) begin
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
      if (w_state_nxt == r_state && r_wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
        w_state_nxt = S_ERR;
        w_err_nxt   = 1'b1;
      end
    end
`else
    w_err_nxt = 1'b0;
`endif
  end

  // Outputs are decoded from the next state so pulses line up with their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      ln1_start    <= 1'b0;
      attn_start   <= 1'b0;
      res1_start   <= 1'b0;
      ln2_start    <= 1'b0;
      mlp_start    <= 1'b0;
      res2_start   <= 1'b0;
      layer_idx    <= '0;
      buf_sel      <= 1'b0;
      mlp_tok_base <= '0;
      mlp_tok_cnt  <= TCNT_W'(TOK_PER_BATCH);
    end else begin
      r_state      <= w_state_nxt;
      busy         <= (w_state_nxt != S_IDLE);
      done         <= (w_state_nxt == S_DONE);
      err_timeout  <= w_err_nxt;
      ln1_start    <= (w_state_nxt == S_LN1);
      attn_start   <= (w_state_nxt == S_ATT);
      res1_start   <= (w_state_nxt == S_RES1);
      ln2_start    <= (w_state_nxt == S_LN2);
      mlp_start    <= (w_state_nxt == S_MLP);
      res2_start   <= (w_state_nxt == S_RES2);
      layer_idx    <= w_layer_nxt;
      buf_sel      <= w_buf_nxt;
      mlp_tok_base <= w_base_nxt;
      mlp_tok_cnt  <= w_cnt_nxt;
    end
  end

`ifdef VIT_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) r_wait_cnt <= '0;
    else     r_wait_cnt <= w_wait_nxt;
  end
`endif

endmodule

// File: doc/vit_encoder_seq_ctrl.md
# vit_encoder_seq_ctrl

Parametrised control sequencer for a stack of ViT encoder layers. It drives one-cycle start pulses to the external LN1, attention, residual-1, LN2, MLP and residual-2 datapath units and waits for each unit's done. It repeats the sequence for NUM_LAYERS layers. The MLP stage is issued in token batches of configurable size, and the block exports layer index, token window and ping-pong buffer select to the weight/activation fetch logic. It sits above the per-layer datapath and replaces the single-layer fixed orchestration with a multi-layer, batched, abortable and watchdog-protected one.

## Interface
Parameters:
- NUM_LAYERS, 4, encoder layers per run (≥1)
- SEQ_LEN, 8, tokens per sequence (≥1)
- TOK_PER_BATCH, 1, tokens per MLP launch (1..SEQ_LEN)
- TIMEOUT_CYC, 4096, watchdog limit in wait-state cycles (≥2; used only with VIT_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  sole clock; rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  cancel the current run
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse; all layers finished
- err_timeout  out  1  sticky watchdog flag
- ln1_start, attn_start, res1_start, ln2_start, mlp_start, res2_start  out  1 each  one-cycle launch pulses
- ln1_done, attn_done, res1_done, ln2_done, mlp_done, res2_done  in  1 each  unit completion
- layer_idx  out  $clog2(NUM_LAYERS) (min 1)  current layer
- buf_sel  out  1  ping-pong activation buffer; toggles per layer
- mlp_tok_base  out  $clog2(SEQ_LEN+1)  first token of current MLP batch
- mlp_tok_cnt  out  $clog2(TOK_PER_BATCH+1)  tokens in current MLP batch

## Operation
- States: IDLE, LN1, W_LN1, ATT, W_ATT, RES1, W_RES1, LN2, W_LN2, MLP, W_MLP, RES2, W_RES2, DONE, ERR.
- Launch states last one cycle. Each asserts its *_start pulse (Moore decode) and moves to its wait state.
- A wait state advances only on its own done input. Done inputs in any other state are ignored.
- Order: LN1 → ATT → RES1 → LN2 → MLP (batched) → RES2.
- MLP batching:
  - Entering LN2 clears mlp_tok_base to 0.
  - Each MLP launch sets mlp_tok_cnt = min(TOK_PER_BATCH, SEQ_LEN − mlp_tok_base).
  - On mlp_done, mlp_tok_base += mlp_tok_cnt. If the new base equals SEQ_LEN, go to RES2; otherwise go back to MLP.
  - mlp_tok_base and mlp_tok_cnt stay stable from the launch cycle through the matching done.
- On res2_done:
  - If layer_idx == NUM_LAYERS−1, go to DONE.
  - Otherwise layer_idx++, buf_sel toggles, and go to LN1.
- DONE lasts one cycle with done=1, then goes to IDLE. layer_idx and buf_sel hold their final values until the next start.
- An accepted start clears layer_idx, buf_sel, mlp_tok_base and err_timeout.
- start while busy is ignored.
- abort in any non-IDLE state (including DONE) forces IDLE at the next edge. No done pulse and no start pulse are issued in that cycle. Counters hold.
- Priority: rst > abort > done input > timeout.

## Timing
- Reset values:
  - busy, done, err_timeout, all *_start: 0
  - layer_idx, buf_sel, mlp_tok_base: 0
  - mlp_tok_cnt: TOK_PER_BATCH
- start sampled at edge k puts ln1_start high in cycle k+1.
- A done sampled at edge n puts the next launch pulse in cycle n+1.
- The fastest stage takes 2 cycles (launch + 1 wait cycle with done high).
- With B = ceil(SEQ_LEN/TOK_PER_BATCH), the minimum run is 2·(5+B)·NUM_LAYERS + 1 (DONE) cycles after start is sampled.
- busy rises the cycle after start is accepted and falls the cycle after DONE/ERR/abort.

## Configuration
- VIT_SEQ_TIMEOUT_EN defined:
  - A wait counter clears on entry to every wait state and increments each wait cycle.
  - If the counter reaches TIMEOUT_CYC−1 with no done, the FSM goes to ERR and sets err_timeout=1.
  - ERR lasts one cycle, then goes to IDLE. No done pulse is issued.
  - err_timeout stays set until rst or an accepted start.
  - A done input in the same cycle wins over the timeout.
- VIT_SEQ_TIMEOUT_EN undefined: no counter; ERR is unreachable; err_timeout is tied to 0.

## Test plan
- NUM_LAYERS=2, SEQ_LEN=8, TOK_PER_BATCH=3, responders return done 1 cycle after start → MLP windows (base,cnt) = (0,3),(3,3),(6,2) per layer; layer_idx 0→1; buf_sel 0→1; single done pulse exactly 33 cycles after start is sampled.
- Pulse res2_done and mlp_done while in W_ATT → ignored; the FSM stays in W_ATT until attn_done.
- Assert start in W_LN2 of layer 0 → no restart; layer_idx and mlp_tok_base unchanged.
- Assert abort during the second MLP batch → IDLE next cycle, busy=0, no done; a new start then begins at layer 0, buf_sel 0.
- VIT_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, attn_done withheld → err_timeout=1 on the 16th W_ATT cycle, IDLE one cycle later, done never pulses; the next start clears err_timeout.
- rst asserted in W_MLP of layer 1 → every output reads its reset value at the next edge; stray done inputs afterwards produce no launch pulses.
